wb_arbiter2: RTL and testbench



---
 rtl/wb_arbiter2_pkg.sv | 24 ++
 rtl/wb_arb_pick.sv | 26 ++
 rtl/wb_arbiter2.sv | 192 +++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encodings,
// the read value returned on a slave timeout, and a grant-decode helper.
// Optional feature macro used by the arbiter: WB_ARB_TIMEOUT_EN.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // Data returned to a master whose slave access timed out
  localparam logic [15:0] TMO_RDATA = 16'hFFFF;

  // One-hot owner vector for a given arbiter state
  function automatic logic [1:0] state_gnt(input arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == ST_OWN0) g = 2'b01;
    if (st == ST_OWN1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Two-way priority pick: requests minus excluded master, tie broken by RR/last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module wb_arb_pick (
  input  logic [1:0] req_i,
  input  logic [1:0] excl_i,
  input  logic       rr_i,
  input  logic       last_i,
  output logic       win_o,
  output logic       vld_o
);

  logic [1:0] eff;

  // Mask out the excluded master, then break a tie (fixed: master 0; rr: not last)
  always_comb begin
    eff   = req_i & ~excl_i;
    vld_o = |eff;
    if (eff == 2'b11) begin
      win_o = rr_i ? ~last_i : 1'b0;
    end else begin
      win_o = eff[1];
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter; grant held for the owner's whole cyc.
// Latency: request from IDLE reaches the slave one cycle after cyc rises; handover is back-to-back.
// Backpressure: a losing master simply waits with cyc/stb held; only the owner sees ack.
// Optional feature macro: WB_ARB_TIMEOUT_EN (slave timeout counter and sticky tmo_o).
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int RR    = 0,
  parameter int TMO_W = 6
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [19:1] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_tga_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  // master 1
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [19:1] m1_adr_i,
  input  logic        m1_we_i,
  input  logic        m1_tga_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  // slave
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic [19:1] s_adr_o,
  output logic        s_we_o,
  output logic        s_tga_o,
  output logic [1:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
`ifdef WB_ARB_TIMEOUT_EN
  output logic        tmo_o,
`endif
  output logic [1:0]  gnt_o
);

  localparam logic RR_EN = (RR != 0);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] pick_excl;
  logic       pick_win, pick_vld;
  logic       tmo_hit;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;
`else
  logic             tmo_w_unused;
  assign tmo_w_unused = ^TMO_W;
`endif

  // The current owner is excluded from the decision made when it releases
  always_comb begin
    pick_excl = 2'b00;
    if (state_q == ST_OWN0) pick_excl = 2'b01;
    if (state_q == ST_OWN1) pick_excl = 2'b10;
  end

  wb_arb_pick u_pick (
    .req_i  ({m1_cyc_i, m0_cyc_i}),
    .excl_i (pick_excl),
    .rr_i   (RR_EN),
    .last_i (last_q),
    .win_o  (pick_win),
    .vld_o  (pick_vld)
  );

`ifdef WB_ARB_TIMEOUT_EN
  // Owner stalled with the counter saturated: abort the access
  assign tmo_hit = (state_q != ST_IDLE) && (&tmo_cnt_q);
`else
  assign tmo_hit = 1'b0;
`endif

  // Next owner: grant from IDLE, hold while cyc stays high, re-arbitrate on release
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = pick_win ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0: begin
        if (!m0_cyc_i || tmo_hit) begin
          last_d  = 1'b0;
          state_d = (pick_vld && !tmo_hit) ? (pick_win ? ST_OWN1 : ST_OWN0) : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i || tmo_hit) begin
          last_d  = 1'b1;
          state_d = (pick_vld && !tmo_hit) ? (pick_win ? ST_OWN1 : ST_OWN0) : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Stall counter restarts on any grant change or slave ack; sticky flag on expiry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q | tmo_hit;
    if ((state_d != state_q) || s_ack_i) begin
      tmo_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && s_stb_o) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end
  assign tmo_o = tmo_q;
`endif

  // All arbiter state; reset drops the grant at once
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Bus steering from the registered owner; read data goes to both, ack only to owner
  always_comb begin
    s_dat_o  = '0;
    s_adr_o  = '0;
    s_we_o   = 1'b0;
    s_tga_o  = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    gnt_o    = state_gnt(state_q);
    case (state_q)
      ST_OWN0: begin
        s_dat_o  = m0_dat_i;
        s_adr_o  = m0_adr_i;
        s_we_o   = m0_we_i;
        s_tga_o  = m0_tga_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
        if (tmo_hit) begin
          m0_ack_o = 1'b1;
          m0_dat_o = TMO_RDATA;
        end
      end
      ST_OWN1: begin
        s_dat_o  = m1_dat_i;
        s_adr_o  = m1_adr_i;
        s_we_o   = m1_we_i;
        s_tga_o  = m1_tga_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
        if (tmo_hit) begin
          m1_ack_o = 1'b1;
          m1_dat_o = TMO_RDATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench: one fixed-priority and one round-robin arbiter on shared stimulus.
// Expected values are hand-derived per step; outputs sampled 1 ns after the rising edge.
// Optional timeout instance exercised when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_dat, m1_dat, s_dat;
  logic [19:1] m0_adr, m1_adr;
  logic        m0_we, m1_we, m0_tga, m1_tga, m0_stb, m1_stb, m0_cyc, m1_cyc, s_ack;
  logic [1:0]  m0_sel, m1_sel;

  logic [15:0] m0_dato [2];
  logic [15:0] m1_dato [2];
  logic [15:0] s_dato  [2];
  logic [19:1] s_adr   [2];
  logic        s_we    [2];
  logic        s_tga   [2];
  logic [1:0]  s_sel   [2];
  logic        s_stb   [2];
  logic        s_cyc   [2];
  logic        m0_ack  [2];
  logic        m1_ack  [2];
  logic [1:0]  gnt     [2];
`ifdef WB_ARB_TIMEOUT_EN
  logic        tmo     [2];
  logic [15:0] t_m0_dato, t_m1_dato, t_s_dato;
  logic [19:1] t_s_adr;
  logic        t_s_we, t_s_tga, t_s_stb, t_s_cyc, t_m0_ack, t_m1_ack, t_tmo;
  logic [1:0]  t_s_sel, t_gnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // index 0: fixed priority, index 1: round-robin
  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter2 #(.RR(g), .TMO_W(6)) u_dut (
      .wb_clk_i (clk),     .wb_rst_i (rst),
      .m0_dat_i (m0_dat),  .m0_dat_o (m0_dato[g]), .m0_adr_i (m0_adr), .m0_we_i (m0_we),
      .m0_tga_i (m0_tga),  .m0_sel_i (m0_sel),     .m0_stb_i (m0_stb), .m0_cyc_i (m0_cyc),
      .m0_ack_o (m0_ack[g]),
      .m1_dat_i (m1_dat),  .m1_dat_o (m1_dato[g]), .m1_adr_i (m1_adr), .m1_we_i (m1_we),
      .m1_tga_i (m1_tga),  .m1_sel_i (m1_sel),     .m1_stb_i (m1_stb), .m1_cyc_i (m1_cyc),
      .m1_ack_o (m1_ack[g]),
      .s_dat_o  (s_dato[g]), .s_dat_i (s_dat),     .s_adr_o (s_adr[g]), .s_we_o (s_we[g]),
      .s_tga_o  (s_tga[g]),  .s_sel_o (s_sel[g]),  .s_stb_o (s_stb[g]), .s_cyc_o (s_cyc[g]),
      .s_ack_i  (s_ack),
`ifdef WB_ARB_TIMEOUT_EN
      .tmo_o    (tmo[g]),
`endif
      .gnt_o    (gnt[g])
    );
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arbiter2 #(.RR(0), .TMO_W(3)) u_tmo (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .m0_dat_i (m0_dat),  .m0_dat_o (t_m0_dato), .m0_adr_i (m0_adr), .m0_we_i (m0_we),
    .m0_tga_i (m0_tga),  .m0_sel_i (m0_sel),    .m0_stb_i (m0_stb), .m0_cyc_i (m0_cyc),
    .m0_ack_o (t_m0_ack),
    .m1_dat_i (m1_dat),  .m1_dat_o (t_m1_dato), .m1_adr_i (m1_adr), .m1_we_i (m1_we),
    .m1_tga_i (m1_tga),  .m1_sel_i (m1_sel),    .m1_stb_i (m1_stb), .m1_cyc_i (m1_cyc),
    .m1_ack_o (t_m1_ack),
    .s_dat_o  (t_s_dato), .s_dat_i (s_dat),     .s_adr_o (t_s_adr), .s_we_o (t_s_we),
    .s_tga_o  (t_s_tga),  .s_sel_o (t_s_sel),   .s_stb_o (t_s_stb), .s_cyc_o (t_s_cyc),
    .s_ack_i  (s_ack),
    .tmo_o    (t_tmo),
    .gnt_o    (t_gnt)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Same expected grant on both arbiters
  task automatic chk_gnt_both(input string tag, input logic [1:0] exp);
    for (int d = 0; d < 2; d++) chk($sformatf("%s_gnt%0d", tag, d), 32'(gnt[d]), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    m0_dat = '0; m1_dat = '0; s_dat = '0; m0_adr = '0; m1_adr = '0;
    m0_we = 0; m1_we = 0; m0_tga = 0; m1_tga = 0; m0_sel = '0; m1_sel = '0;
    m0_stb = 0; m1_stb = 0; m0_cyc = 0; m1_cyc = 0; s_ack = 0;
    step(); step();
    rst = 1'b0;
    m0_adr = 19'h00010;
    s_ack = 1'b1;
    #1;
    // reset / idle state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_cyc%0d", d), 32'(s_cyc[d]), 0);
      chk($sformatf("rst_stb%0d", d), 32'(s_stb[d]), 0);
      chk($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 0);
      chk($sformatf("rst_ack0_%0d", d), 32'(m0_ack[d]), 0);
      chk($sformatf("rst_ack1_%0d", d), 32'(m1_ack[d]), 0);
      chk($sformatf("idle_adr%0d", d), 32'(s_adr[d]), 0);
    end
    s_ack = 1'b0;

    // m0 single request: one-cycle grant latency
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 2'b11; m0_tga = 1; m0_dat = 16'h1234;
    #1;
    chk("lat_cyc0", 32'(s_cyc[0]), 0);
    step();
    chk_gnt_both("own0", 2'b01);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("own0_adr%0d", d), 32'(s_adr[d]), 32'h00010);
      chk($sformatf("own0_cyc%0d", d), 32'(s_cyc[d]), 1);
      chk($sformatf("own0_wdat%0d", d), 32'(s_dato[d]), 32'h1234);
    end
    chk("own0_we", 32'(s_we[0]), 1);
    chk("own0_sel", 32'(s_sel[0]), 3);
    chk("own0_tga", 32'(s_tga[0]), 1);

    // first ack, read data visible to both masters, ack only to owner
    s_ack = 1; s_dat = 16'hBEEF;
    #1;
    chk("ack1_m0", 32'(m0_ack[0]), 1);
    chk("ack1_m1", 32'(m1_ack[0]), 0);
    chk("rdat_m0", 32'(m0_dato[0]), 32'hBEEF);
    chk("rdat_m1", 32'(m1_dato[1]), 32'hBEEF);
    step();

    // split access: m0 keeps cyc between strobes while m1 waits
    s_ack = 0; m0_stb = 0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 19'h7FFFF; m1_we = 0; m1_sel = 2'b01; m1_tga = 0;
    m1_dat = 16'hA5A5;
    step();
    chk_gnt_both("split_gap", 2'b01);
    m0_stb = 1; m0_adr = 19'h00011;
    step();
    s_ack = 1;
    #1;
    chk("ack2_m0", 32'(m0_ack[1]), 1);
    chk("ack2_m1", 32'(m1_ack[1]), 0);
    chk("ack2_adr", 32'(s_adr[0]), 32'h00011);
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    chk_gnt_both("rel_pre", 2'b01);
    step();
    chk_gnt_both("handover", 2'b10);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("own1_adr%0d", d), 32'(s_adr[d]), 32'h7FFFF);
      chk($sformatf("own1_wdat%0d", d), 32'(s_dato[d]), 32'hA5A5);
    end
    chk("own1_sel", 32'(s_sel[1]), 1);
    chk("own1_we", 32'(s_we[1]), 0);
    s_ack = 1;
    #1;
    chk("own1_ack1", 32'(m1_ack[0]), 1);
    chk("own1_ack0", 32'(m0_ack[0]), 0);
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
    chk_gnt_both("idle2", 2'b00);
    chk("idle2_cyc", 32'(s_cyc[1]), 0);
    chk("idle2_sel", 32'(s_sel[0]), 0);

    // tie from IDLE straight after reset: both pick master 0
    rst = 1; step(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    chk_gnt_both("tie_rst", 2'b01);

    // continuous single-ack cycles from both masters: owner drops cyc for one cycle
    s_ack = 1; step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; step();
    chk_gnt_both("alt1", 2'b10);
    m0_cyc = 1; m0_stb = 1; s_ack = 1; step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; step();
    chk_gnt_both("alt2", 2'b01);
    m1_cyc = 1; m1_stb = 1; s_ack = 1; step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; step();
    chk_gnt_both("alt3", 2'b10);
    m1_cyc = 0; m1_stb = 0; step();
    chk_gnt_both("alt_idle", 2'b00);

    // tie from IDLE with last = 0: fixed picks m0, round-robin picks m1
    m0_cyc = 1; m0_stb = 1; step();
    m0_cyc = 0; m0_stb = 0; step();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    chk("tie_fix", 32'(gnt[0]), 32'h1);
    chk("tie_rr", 32'(gnt[1]), 32'h2);
    s_ack = 1;
    #1;
    chk("tie_fix_ack0", 32'(m0_ack[0]), 1);
    chk("tie_fix_ack1", 32'(m1_ack[0]), 0);
    chk("tie_rr_ack0", 32'(m0_ack[1]), 0);
    chk("tie_rr_ack1", 32'(m1_ack[1]), 1);
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
    chk_gnt_both("tie_idle", 2'b00);

    // reset in the middle of an OWN1 cycle
    m1_cyc = 1; m1_stb = 1; step();
    chk_gnt_both("pre_rst", 2'b10);
    rst = 1; s_ack = 1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mrst_cyc%0d", d), 32'(s_cyc[d]), 0);
      chk($sformatf("mrst_stb%0d", d), 32'(s_stb[d]), 0);
      chk($sformatf("mrst_gnt%0d", d), 32'(gnt[d]), 0);
      chk($sformatf("mrst_ack1_%0d", d), 32'(m1_ack[d]), 0);
    end
    rst = 0; s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks: 3-bit counter expires after 7 stalled cycles
    chk("tmo_init", 32'(t_tmo), 0);
    m0_cyc = 1; m0_stb = 1; s_dat = 16'h0001;
    step();
    chk("tmo_gnt", 32'(t_gnt), 1);
    repeat (6) step();
    chk("tmo_early", 32'(t_m0_ack), 0);
    step();
    chk("tmo_ack", 32'(t_m0_ack), 1);
    chk("tmo_dat", 32'(t_m0_dato), 32'hFFFF);
    chk("tmo_ack1", 32'(t_m1_ack), 0);
    chk("tmo_other_dut", 32'(m0_ack[0]), 0);
    step();
    chk("tmo_idle", 32'(t_gnt), 0);
    chk("tmo_cyc", 32'(t_s_cyc), 0);
    chk("tmo_flag", 32'(t_tmo), 1);
    chk("tmo_ref_gnt", 32'(gnt[0]), 1);
    m0_cyc = 0; m0_stb = 0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
